// File: rtl/bcdcnt_scan.sv
// ---------------------------------------------------------------------------
// bcdcnt_scan
//
// N-digit BCD counter with up/down counting, synchronous parallel load,
// a registered terminal-count pulse, and a time-multiplexed 7-segment
// scan driver for common-segment multi-digit displays.
//
// Parameters
//   DIGITS    number of BCD digits (2..8); count width is 4*DIGITS
//   SCAN_DIV  clocks each digit stays selected before the scan advances (>=2)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset (released synchronously inside)
//   en        count enable, one step per clock while high
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel load, priority over en
//   load_val  BCD load value, digit k in bits [4k+3:4k]; digits >9 load as 0
//   count     current BCD count, digit 0 least significant
//   tc        one-cycle pulse coincident with a wrap (all-0s up / all-9s down)
//   seg       active-high segments, seg[0]=a .. seg[6]=g
//   an        one-hot, active-high digit select
//
// Build option
//   LZ_BLANK_EN  when defined, leading zeros (digit k>0 with every digit >=k
//                equal to 0) are shown blank; digit 0 is never blanked.
// ---------------------------------------------------------------------------
module bcdcnt_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    GLYPH_ZERO = 7'b0111111;

  // Segment encoding for one BCD digit; non-BCD values never reach here.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // -------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge so that all
  // state leaves reset in the same cycle.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  // rst itself is ORed in so outputs clear with no clock even on the very
  // first assertion, before the synchroniser flops have been set.
  assign rst_int = rst | rst_sync_q[1];

  // -------------------------------------------------------------------------
  // Counter
  // -------------------------------------------------------------------------
  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;

  logic [CW-1:0] inc_val, dec_val, load_clean;
  logic          carry, borrow;
  logic [3:0]    cdig, ldig;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    count_d    = count_q;
    tc_d       = 1'b0;
    inc_val    = count_q;
    dec_val    = count_q;
    load_clean = '0;
    cdig       = 4'd0;
    ldig       = 4'd0;
    // NOTE: carry/borrow are blocking temporaries evaluated in loop order,
    // forming the ripple chain from digit 0 upward within one evaluation.
    carry      = 1'b1;
    borrow     = 1'b1;

    for (int k = 0; k < DIGITS; k++) begin
      cdig = count_q[4*k +: 4];
      ldig = load_val[4*k +: 4];

      if (carry) begin
        inc_val[4*k +: 4] = (cdig == 4'd9) ? 4'd0 : cdig + 4'd1;
      end
      if (borrow) begin
        dec_val[4*k +: 4] = (cdig == 4'd0) ? 4'd9 : cdig - 4'd1;
      end
      // A digit only passes the carry/borrow on if it wrapped itself.
      carry  = carry  & (cdig == 4'd9);
      borrow = borrow & (cdig == 4'd0);

      load_clean[4*k +: 4] = (ldig > 4'd9) ? 4'd0 : ldig;
    end

    // After the loop, carry = "count was all 9s", borrow = "all 0s":
    // exactly the wrap conditions for the respective direction.
    if (load) begin
      count_d = load_clean;
    end else if (en) begin
      count_d = up ? inc_val : dec_val;
      tc_d    = up ? carry   : borrow;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scan prescaler and digit index (free-running, ignores en/load)
  // -------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Display registers. an and seg are both derived from the same idx_q and
  // count_q and registered on the same edge, so a selected digit is never
  // paired with another digit's glyph.
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        sel_digit;
  logic              sel_blank;

`ifdef LZ_BLANK_EN
  logic zero_hi;

  // blank[k] is set when digit k and every digit above it are zero.
  always_comb begin
    blank   = '0;
    zero_hi = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_hi  = zero_hi & (count_q[4*k +: 4] == 4'd0);
      blank[k] = zero_hi;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    an_d      = '0;
    sel_digit = count_q[3:0];
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        an_d[i]   = 1'b1;
        sel_digit = count_q[4*i +: 4];
        sel_blank = blank[i];
      end
    end
    seg_d = sel_blank ? 7'b0000000 : glyph(sel_digit);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      an_q  <= DIGITS'(1);
      seg_q <= GLYPH_ZERO;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_bcdcnt_scan.sv
// ---------------------------------------------------------------------------
// tb_bcdcnt_scan
//
// Directed bench for bcdcnt_scan with DIGITS=4, SCAN_DIV=4. A table of
// {load, en, up, load_val, expected count, expected tc} records drives the
// counter one clock per row; hand-written sequences cover the scan
// sequence, leading-zero display and asynchronous reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcdcnt_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc;
  logic [6:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  bcdcnt_scan #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tc      (tc),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        en;
    logic        up;
    logic [15:0] val;
    logic [15:0] exp_cnt;
    logic        exp_tc;
  } vec_t;

  vec_t vecs[$];

  logic [6:0] glyph_t [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (on falling edges) until an matches / differs from target.
  task automatic wait_an(input logic [3:0] target, input bit want_equal,
                         input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if ((an == target) == want_equal) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic load_value(input logic [15:0] v);
    load     = 1'b1;
    en       = 1'b0;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Observe one full refresh (DIGITS*SCAN_DIV clocks) starting at digit 0
  // and compare an/seg against the expected glyph for the displayed value.
  task automatic scan_check(input logic [15:0] v, input string tag);
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    int         d;
    wait_an(4'b0001, 1'b0, {tag, "_leave0"});
    wait_an(4'b0001, 1'b1, {tag, "_enter0"});
    for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
      d       = i / SCAN_DIV;
      exp_an  = 4'(1 << d);
      exp_seg = glyph_t[v[4*d +: 4]];
`ifdef LZ_BLANK_EN
      if (d > 0 && (v >> (4 * d)) == 16'h0) exp_seg = 7'b0000000;
`endif
      check($sformatf("%s_an_%0d", tag, i), {28'd0, an}, {28'd0, exp_an});
      check($sformatf("%s_seg_%0d", tag, i), {25'd0, seg}, {25'd0, exp_seg});
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 16'h0;

    //            ld  en  up  load_val  exp_cnt   tc
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h9998, 16'h9998, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0999, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h9998, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'h12F4, 16'h1204, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h1235, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0999, 16'h0999, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'hA5B3, 16'h0503, 1'b0});

    // Reset state before any clock edge.
    #2;
    check("rst_count", {16'd0, count}, 32'h0);
    check("rst_tc", {31'd0, tc}, 32'd0);
    check("rst_an", {28'd0, an}, 32'b0001);
    check("rst_seg", {25'd0, seg}, 32'b0111111);

    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_count", {16'd0, count}, 32'h0);

    // Table-driven counter vectors: one clock per row.
    for (int i = 0; i < vecs.size(); i++) begin
      load     = vecs[i].ld;
      en       = vecs[i].en;
      up       = vecs[i].up;
      load_val = vecs[i].val;
      @(negedge clk);
      check($sformatf("vec%0d_count", i), {16'd0, count}, {16'd0, vecs[i].exp_cnt});
      check($sformatf("vec%0d_tc", i), {31'd0, tc}, {31'd0, vecs[i].exp_tc});
    end
    load = 1'b0;
    en   = 1'b0;

    // Scan sequence with a fixed count.
    load_value(16'h1234);
    check("scan_load", {16'd0, count}, 32'h1234);
    scan_check(16'h1234, "scan1234");

    // Leading zeros: blanked when LZ_BLANK_EN is defined, shown otherwise.
    load_value(16'h0050);
    scan_check(16'h0050, "scan0050");

    // Asynchronous reset in the middle of a scan, between clock edges.
    wait_an(4'b0100, 1'b1, "mid_an");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", {16'd0, count}, 32'h0);
    check("async_rst_tc", {31'd0, tc}, 32'd0);
    check("async_rst_an", {28'd0, an}, 32'b0001);
    check("async_rst_seg", {25'd0, seg}, 32'b0111111);

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
